// File: rtl/ioread_pkg.sv
// ioread_pkg: shared defaults and helpers for the switch-input capture slice.
//   DEF_DATA_W / DEF_NUM_CH / DEF_DEBOUNCE_CYC : default parameter values
//   ch_idx_w(n) : channel index width, max(1, $clog2(n))
package ioread_pkg;

  localparam int DEF_DATA_W       = 8;
  localparam int DEF_NUM_CH       = 2;
  localparam int DEF_DEBOUNCE_CYC = 16;

  function automatic int ch_idx_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser followed by a whole-word debouncer.
//   clk, reset : clock, synchronous active-high reset
//   sw_in      : raw asynchronous switch bus
//   sw_stable  : debounced value, updated after DEBOUNCE_CYC stable cycles
module sw_debounce #(
  parameter int DATA_W       = 8,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sw_in,
  output logic [DATA_W-1:0] sw_stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic [DATA_W-1:0] sync1;
  logic [DATA_W-1:0] sync2;
  logic [DATA_W-1:0] cand;
  logic [CNT_W-1:0]  cnt;

  // Any bit difference restarts the whole word; once the count reaches its
  // terminal value it saturates and keeps reloading sw_stable from cand.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      cand      <= '0;
      cnt       <= '0;
      sw_stable <= '0;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt == CNT_MAX) begin
        sw_stable <= cand;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ioread_capture.sv
// ioread_capture: debounced switch capture with per-channel registers,
// sticky new-data flags and a registered one-cycle read response.
//   clk, reset : clock, synchronous active-high reset
//   sw_in      : raw switch bus
//   ior/ior_ch : capture strobe and target channel
//   rd/rd_ch   : read request and source channel
//   rd_data    : registered read data (holds when no read)
//   rd_valid   : one-cycle pulse per read
//   new_flags  : per-channel "captured since last read"
//   sw_stable  : current debounced switch value
module ioread_capture
  import ioread_pkg::*;
#(
  parameter  int DATA_W       = DEF_DATA_W,
  parameter  int NUM_CH       = DEF_NUM_CH,
  parameter  int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  localparam int CH_W         = ch_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sw_in,
  input  logic              ior,
  input  logic [CH_W-1:0]   ior_ch,
  input  logic              rd,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [NUM_CH-1:0] new_flags,
  output logic [DATA_W-1:0] sw_stable
);

  logic [DATA_W-1:0] cap [NUM_CH];
  logic [NUM_CH-1:0] cap_hit;
  logic [NUM_CH-1:0] rd_hit;
  logic [DATA_W-1:0] rd_mux;

  sw_debounce #(
    .DATA_W       (DATA_W),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .sw_in     (sw_in),
    .sw_stable (sw_stable)
  );

  // Per-channel decode replaces a range check: an out-of-range index simply
  // matches no channel, so it writes nothing, clears nothing and reads 0.
  always_comb begin
    cap_hit = '0;
    rd_hit  = '0;
    rd_mux  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cap_hit[i] = ior && (ior_ch == CH_W'(i));
      rd_hit[i]  = rd && (rd_ch == CH_W'(i));
      if (rd_ch == CH_W'(i)) rd_mux = cap[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) cap[i] <= '0;
      new_flags <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= rd;
      if (rd) rd_data <= rd_mux;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (cap_hit[i]) begin
          cap[i]       <= sw_stable;
          new_flags[i] <= 1'b1;
        end else if (rd_hit[i]) begin
          new_flags[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ioread_capture.sv
module tb_ioread_capture;

  localparam int DATA_W = 8;
  localparam int NUM_CH = 2;
  localparam int DEB    = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] sw_in;
  logic              ior;
  logic [0:0]        ior_ch;
  logic              rd;
  logic [0:0]        rd_ch;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [NUM_CH-1:0] new_flags;
  logic [DATA_W-1:0] sw_stable;

  int n_checks = 0;
  int n_fail   = 0;

  ioread_capture #(
    .DATA_W       (DATA_W),
    .NUM_CH       (NUM_CH),
    .DEBOUNCE_CYC (DEB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sw_in     (sw_in),
    .ior       (ior),
    .ior_ch    (ior_ch),
    .rd        (rd),
    .rd_ch     (rd_ch),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .new_flags (new_flags),
    .sw_stable (sw_stable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; sw_in = '0; ior = 1'b0; ior_ch = '0; rd = 1'b0; rd_ch = '0;
    tick(2);
    reset = 1'b0;
    tick(10);
    chk("rst_rd_data",   32'(rd_data),   32'h00);
    chk("rst_rd_valid",  32'(rd_valid),  32'h0);
    chk("rst_new_flags", 32'(new_flags), 32'h0);
    chk("rst_sw_stable", 32'(sw_stable), 32'h00);

    // Debounce latency: stable updates on the 7th edge after the change.
    sw_in = 8'hA5;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk($sformatf("deb_a5_e%0d", e), 32'(sw_stable), (e < 7) ? 32'h00 : 32'hA5);
    end

    // Short glitch never reaches sw_stable; second value lands on edge 7.
    sw_in = 8'h3C;
    tick(2);
    chk("glitch_hold", 32'(sw_stable), 32'hA5);
    sw_in = 8'hC3;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk($sformatf("deb_c3_e%0d", e), 32'(sw_stable), (e < 7) ? 32'hA5 : 32'hC3);
    end

    // Capture ch1 then read ch1.
    sw_in = 8'h5A;
    tick(8);
    chk("stable_5a", 32'(sw_stable), 32'h5A);
    ior = 1'b1; ior_ch = 1'b1;
    tick();
    ior = 1'b0;
    chk("ior1_flags", 32'(new_flags), 32'h2);
    rd = 1'b1; rd_ch = 1'b1;
    tick();
    rd = 1'b0;
    chk("rd1_data",  32'(rd_data),   32'h5A);
    chk("rd1_valid", 32'(rd_valid),  32'h1);
    chk("rd1_flags", 32'(new_flags), 32'h0);
    tick();
    chk("idle_valid", 32'(rd_valid), 32'h0);
    chk("idle_hold",  32'(rd_data),  32'h5A);

    // Same-channel capture and read in one cycle.
    sw_in = 8'h11;
    tick(8);
    ior = 1'b1; ior_ch = 1'b0;
    tick();
    ior = 1'b0;
    chk("cap0_flags", 32'(new_flags), 32'h1);
    sw_in = 8'h22;
    tick(8);
    chk("stable_22", 32'(sw_stable), 32'h22);
    ior = 1'b1; ior_ch = 1'b0; rd = 1'b1; rd_ch = 1'b0;
    tick();
    ior = 1'b0; rd = 1'b0;
    chk("same_rd_old", 32'(rd_data),   32'h11);
    chk("same_valid",  32'(rd_valid),  32'h1);
    chk("same_flags",  32'(new_flags), 32'h1);
    rd = 1'b1; rd_ch = 1'b0;
    tick();
    rd = 1'b0;
    chk("rd0_new",   32'(rd_data),   32'h22);
    chk("rd0_flags", 32'(new_flags), 32'h0);

    // Different channels in one cycle: capture ch1 (0x22), read ch0 (0x22).
    ior = 1'b1; ior_ch = 1'b1; rd = 1'b1; rd_ch = 1'b0;
    tick();
    ior = 1'b0; rd = 1'b0;
    chk("diff_rd",    32'(rd_data),   32'h22);
    chk("diff_flags", 32'(new_flags), 32'h2);

    // Back-to-back reads of ch1, then reset with rd still high.
    rd = 1'b1; rd_ch = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk($sformatf("b2b_valid_%0d", e), 32'(rd_valid), 32'h1);
      chk($sformatf("b2b_data_%0d", e),  32'(rd_data),  32'h22);
    end
    chk("b2b_flags", 32'(new_flags), 32'h0);
    reset = 1'b1;
    tick();
    chk("rstrd_valid",  32'(rd_valid),  32'h0);
    chk("rstrd_data",   32'(rd_data),   32'h00);
    chk("rstrd_flags",  32'(new_flags), 32'h0);
    chk("rstrd_stable", 32'(sw_stable), 32'h00);
    reset = 1'b0; rd = 1'b0;
    tick();
    chk("post_rst_valid", 32'(rd_valid), 32'h0);

    // Captures were wiped by reset: a read of ch1 returns 0.
    rd = 1'b1; rd_ch = 1'b1;
    tick();
    rd = 1'b0;
    chk("post_rst_cap1", 32'(rd_data), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
